// File: rtl/video_window_gen.sv
// video_window_gen: recovers a pixel clock-enable, resynchronised syncs,
// h/v position counters and blanking windows from the core's raw hs/vs.
// Optional feature macro: VIDEO_WINDOW_MEASURE_EN builds line/frame
// measurement and the lock FSM; blanking is then also forced while unlocked.
// Without it, line_len/frame_lines read 0 and locked reads 1.
module video_window_gen #(
  parameter int unsigned CE_DIV      = 16,
  parameter int unsigned CNT_W       = 9,
  parameter int unsigned H_START     = 34,
  parameter int unsigned H_END       = 214,
  parameter int unsigned V_START     = 25,
  parameter int unsigned V_END       = 254,
  parameter int unsigned LOCK_FRAMES = 3
) (
  input  logic             clk_sys,
  input  logic             reset_l,
  input  logic             hs_in,
  input  logic             vs_in,
  output logic             ce_pix,
  output logic             hsync,
  output logic             vsync,
  output logic             hblank,
  output logic             vblank,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic [CNT_W-1:0] line_len,
  output logic [CNT_W-1:0] frame_lines,
  output logic             locked
);

  localparam int unsigned      DIV_W    = $clog2(CE_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CE_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Counters stick at all-ones instead of wrapping, so a lost sync is visible.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == CNT_MAX) ? x : x + 1'b1;
  endfunction

  logic [DIV_W-1:0] div;
  logic             line_start;
  logic             frame_start;
  logic             h_win_blank;
  logic             v_win_blank;

  // Edges are detected against the resynchronised copies, on pixel ticks only.
  assign line_start  = ce_pix & hs_in & ~hsync;
  assign frame_start = line_start & vs_in & ~vsync;

  assign h_win_blank = (h_cnt >= CNT_W'(H_END)) | (h_cnt < CNT_W'(H_START));
  assign v_win_blank = (v_cnt < CNT_W'(V_START)) | (v_cnt > CNT_W'(V_END));

  // Clock divider; ce_pix is high for the one clock after div reaches its last count.
  always_ff @(posedge clk_sys or negedge reset_l) begin
    if (!reset_l) begin
      div    <= '0;
      ce_pix <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      div    <= (div == DIV_LAST) ? '0 : div + 1'b1;
      ce_pix <= (div == DIV_LAST);
    end
  end

  // Sync resampling and h/v position counters, advanced on pixel ticks.
  always_ff @(posedge clk_sys or negedge reset_l) begin
    if (!reset_l) begin
      hsync <= 1'b0;
      vsync <= 1'b0;
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (ce_pix) begin
      hsync <= hs_in;
      if (line_start) begin
        h_cnt <= '0;
        vsync <= vs_in;
        v_cnt <= frame_start ? '0 : sat_inc(v_cnt);
      end else begin
        h_cnt <= sat_inc(h_cnt);
      end
    end
  end

`ifdef VIDEO_WINDOW_MEASURE_EN
  typedef enum logic [1:0] {UNLOCKED, COUNTING, LOCKED} lock_state_e;

  lock_state_e      state_q, state_d;
  logic [3:0]       mc_q, mc_d;
  logic [CNT_W-1:0] ll_new, fl_new, prev_ll;
  logic             sat_seen, sat_now, match;

  assign ll_new  = sat_inc(h_cnt);
  assign fl_new  = sat_inc(v_cnt);
  assign sat_now = (h_cnt == CNT_MAX) | (v_cnt == CNT_MAX);
  // frame_lines still holds the previous frame's capture; prev_ll holds its line length.
  assign match   = (ll_new == prev_ll) && (fl_new == frame_lines);

  // Line/frame measurement capture and saturation tracking between frame starts.
  always_ff @(posedge clk_sys or negedge reset_l) begin
    if (!reset_l) begin
      line_len    <= '0;
      frame_lines <= '0;
      prev_ll     <= '0;
      sat_seen    <= 1'b0;
    end else begin
      if (frame_start)  sat_seen <= 1'b0;
      else if (sat_now) sat_seen <= 1'b1;
      if (line_start) line_len <= ll_new;
      if (frame_start) begin
        frame_lines <= fl_new;
        prev_ll     <= ll_new;
      end
    end
  end

  // Lock FSM state register.
  always_ff @(posedge clk_sys or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= UNLOCKED;
      mc_q    <= '0;
    end else begin
      state_q <= state_d;
      mc_q    <= mc_d;
    end
  end

  // Lock FSM next-state, evaluated only on frame starts.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    state_d = state_q;
    mc_d    = mc_q;
    if (frame_start) begin
      unique case (state_q)
        UNLOCKED: begin
          state_d = COUNTING;
          mc_d    = '0;
        end
        COUNTING: begin
          if (match) begin
            mc_d = mc_q + 4'd1;
            if (mc_q + 4'd1 == 4'(LOCK_FRAMES)) state_d = LOCKED;
          end else begin
            mc_d = '0;
          end
        end
        LOCKED: begin
          if (!match || sat_seen || sat_now) begin
            state_d = UNLOCKED;
            mc_d    = '0;
          end
        end
        default: begin
          state_d = UNLOCKED;
          mc_d    = '0;
        end
      endcase
    end
  end

  assign locked = (state_q == LOCKED);
  assign hblank = h_win_blank | ~locked;
  assign vblank = v_win_blank | ~locked;
`else
  assign line_len    = '0;
  assign frame_lines = '0;
  assign locked      = 1'b1;
  assign hblank      = h_win_blank;
  assign vblank      = v_win_blank;
`endif

endmodule

// File: tb/tb_video_window_gen.sv
// Directed bench for video_window_gen. Instance a uses the default parameters
// (pixel-enable timing and the horizontal window on a 455-pixel line);
// instance b is scaled down (CE_DIV=2, CNT_W=6, 24-pixel lines, 10/11-line
// frames) so locking, relocking, saturation and reset fit in a short run.
module tb_video_window_gen;

`ifdef VIDEO_WINDOW_MEASURE_EN
  localparam bit MEAS = 1'b1;
`else
  localparam bit MEAS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- instance a: default parameters ----------------
  logic       rst_a, hs_a, vs_a;
  logic       ce_a, hsync_a, vsync_a, hblank_a, vblank_a, locked_a;
  logic [8:0] h_cnt_a, v_cnt_a, ll_a, fl_a;

  video_window_gen u_dut_a (
    .clk_sys(clk), .reset_l(rst_a), .hs_in(hs_a), .vs_in(vs_a),
    .ce_pix(ce_a), .hsync(hsync_a), .vsync(vsync_a),
    .hblank(hblank_a), .vblank(vblank_a),
    .h_cnt(h_cnt_a), .v_cnt(v_cnt_a), .line_len(ll_a), .frame_lines(fl_a),
    .locked(locked_a)
  );

  // ---------------- instance b: scaled parameters ----------------
  logic       rst_b, hs_b, vs_b;
  logic       ce_b, hsync_b, vsync_b, hblank_b, vblank_b, locked_b;
  logic [5:0] h_cnt_b, v_cnt_b, ll_b, fl_b;

  video_window_gen #(
    .CE_DIV(2), .CNT_W(6), .H_START(4), .H_END(20),
    .V_START(2), .V_END(6), .LOCK_FRAMES(3)
  ) u_dut_b (
    .clk_sys(clk), .reset_l(rst_b), .hs_in(hs_b), .vs_in(vs_b),
    .ce_pix(ce_b), .hsync(hsync_b), .vsync(vsync_b),
    .hblank(hblank_b), .vblank(vblank_b),
    .h_cnt(h_cnt_b), .v_cnt(v_cnt_b), .line_len(ll_b), .frame_lines(fl_b),
    .locked(locked_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected value of a measurement/lock output given the measuring build's value.
  function automatic logic [31:0] exp_meas(input logic [31:0] v);
    return MEAS ? v : 32'd0;
  endfunction
  function automatic logic exp_lock(input logic l);
    return MEAS ? l : 1'b1;
  endfunction

  // Apply inputs, let exactly one pixel tick consume them, return just after it.
  task automatic px_a(input logic hs, input logic vs);
    hs_a = hs;
    vs_a = vs;
    for (int i = 0; i < 40 && !ce_a; i++) @(negedge clk);
    if (!ce_a) check("a_tick_timeout", ce_a, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic px_b(input logic hs, input logic vs);
    hs_b = hs;
    vs_b = vs;
    for (int i = 0; i < 10 && !ce_b; i++) @(negedge clk);
    if (!ce_b) check("b_tick_timeout", ce_b, 1'b1);
    @(posedge clk);
    #1;
  endtask

  // One 24-pixel line on b (hs high 4 pixels); optionally checks hblank edges.
  task automatic line_b(input logic vs, input bit chk, input bit lk);
    for (int j = 0; j < 24; j++) begin
      px_b(j < 4, vs);
      if (chk && (j == 3 || j == 4 || j == 19 || j == 20))
        check($sformatf("b_hblank_px%0d", j), hblank_b,
              (j < 4) || (j >= 20) || (MEAS && !lk));
    end
  endtask

  // A frame of n lines on b; vs is high during its first three lines.
  task automatic frame_b(input int n);
    for (int k = 0; k < n; k++) line_b(k < 3, 1'b0, 1'b0);
  endtask

  task automatic check_b_reset(input string tag);
    check({tag, "_ce"},     ce_b, 1'b0);
    check({tag, "_hsync"},  hsync_b, 1'b0);
    check({tag, "_vsync"},  vsync_b, 1'b0);
    check({tag, "_h_cnt"},  h_cnt_b, 0);
    check({tag, "_v_cnt"},  v_cnt_b, 0);
    check({tag, "_ll"},     ll_b, 0);
    check({tag, "_fl"},     fl_b, 0);
    check({tag, "_locked"}, locked_b, exp_lock(1'b0));
    check({tag, "_hblank"}, hblank_b, 1'b1);
    check({tag, "_vblank"}, vblank_b, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b0; hs_a = 1'b0; vs_a = 1'b0;
    rst_b = 1'b0; hs_b = 1'b0; vs_b = 1'b0;
    repeat (3) @(negedge clk);

    // ---- a: reset values ----
    check("a_rst_ce", ce_a, 1'b0);
    check("a_rst_h_cnt", h_cnt_a, 0);
    check("a_rst_hblank", hblank_a, 1'b1);
    check("a_rst_vblank", vblank_a, 1'b1);
    check("a_rst_locked", locked_a, exp_lock(1'b0));

    // ---- a: first ce_pix at clock 16 after release, then every 16 ----
    rst_a = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("a_ce_clk%0d", k), ce_a, (k % 16) == 0);
    end

    // ---- a: two 455-pixel lines, hs high 32 pixels ----
    for (int j = 0; j < 455; j++) begin
      px_a(j < 32, 1'b0);
      if (j == 454) check("a_h_cnt_line_end", h_cnt_a, 454);
    end
    for (int j = 0; j < 455; j++) begin
      px_a(j < 32, 1'b0);
      if (j == 0) begin
        check("a_h_cnt_restart", h_cnt_a, 0);
        check("a_line_len", ll_a, exp_meas(455));
        check("a_v_cnt", v_cnt_a, 2);
        check("a_vblank", vblank_a, 1'b1);
        check("a_hsync_rise", hsync_a, 1'b1);
      end
      if (j == 32) check("a_hsync_fall", hsync_a, 1'b0);
      if (j == 0 || j == 33 || j == 34 || j == 213 || j == 214 || j == 454)
        check($sformatf("a_hblank_h%0d", j), hblank_a,
              MEAS || (j < 34) || (j >= 214));
    end

    // ---- b: reset values, then lock on 10-line frames ----
    check_b_reset("b_rst");
    @(negedge clk);
    rst_b = 1'b1;
    repeat (4) frame_b(10);
    check("b_h_cnt_end", h_cnt_b, 23);
    check("b_v_cnt_end", v_cnt_b, 9);
    check("b_line_len", ll_b, exp_meas(24));
    check("b_frame_lines", fl_b, exp_meas(10));
    check("b_locked_before", locked_b, exp_lock(1'b0));
    line_b(1'b1, 1'b0, 1'b0);
    check("b_locked_3rd_match", locked_b, exp_lock(1'b1));
    check("b_v_cnt_after_vs", v_cnt_b, 0);
    check("b_vsync_high", vsync_b, 1'b1);
    line_b(1'b1, 1'b1, 1'b1);
    for (int k = 2; k < 10; k++) begin
      line_b(k < 3, 1'b0, 1'b0);
      check($sformatf("b_vblank_line%0d", k), vblank_b, (k < 2) || (k > 6));
      if (k == 3) check("b_vsync_low", vsync_b, 1'b0);
    end

    // ---- b: switch to 11-line frames: drop, then relock ----
    frame_b(11);
    check("b_locked_keep", locked_b, exp_lock(1'b1));
    line_b(1'b1, 1'b0, 1'b0);
    check("b_locked_drop", locked_b, exp_lock(1'b0));
    check("b_frame_lines_11", fl_b, exp_meas(11));
    for (int k = 1; k < 11; k++) line_b(k < 3, 1'b0, 1'b0);
    repeat (3) frame_b(11);
    check("b_relock_pending", locked_b, exp_lock(1'b0));
    line_b(1'b1, 1'b0, 1'b0);
    check("b_relocked", locked_b, exp_lock(1'b1));
    for (int k = 1; k < 11; k++) line_b(k < 3, 1'b0, 1'b0);

    // ---- b: asynchronous reset mid-line while locked ----
    for (int j = 0; j < 5; j++) px_b(j < 3, 1'b0);
    check("b_mid_h_cnt", h_cnt_b, 4);
    #2;
    rst_b = 1'b0;
    #1;
    check_b_reset("b_async");
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    repeat (4) frame_b(10);
    check("b_reacq_pending", locked_b, exp_lock(1'b0));
    line_b(1'b1, 1'b0, 1'b0);
    check("b_reacquired", locked_b, exp_lock(1'b1));
    for (int k = 1; k < 10; k++) line_b(k < 3, 1'b0, 1'b0);

    // ---- b: hs held low 70 pixels saturates h_cnt; unlock at next frame start ----
    line_b(1'b1, 1'b0, 1'b0);
    check("b_locked_pre_sat", locked_b, exp_lock(1'b1));
    for (int j = 0; j < 74; j++) px_b(j < 4, 1'b1);
    check("b_h_cnt_sat", h_cnt_b, 63);
    line_b(1'b1, 1'b0, 1'b0);
    check("b_line_len_sat", ll_b, exp_meas(63));
    for (int k = 3; k < 10; k++) line_b(1'b0, 1'b0, 1'b0);
    check("b_locked_sat_mid", locked_b, exp_lock(1'b1));
    line_b(1'b1, 1'b0, 1'b0);
    check("b_locked_sat_drop", locked_b, exp_lock(1'b0));
    check("b_frame_lines_sat", fl_b, exp_meas(10));
    check("b_line_len_after", ll_b, exp_meas(24));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
